alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit alu_cmd, REG_WIDTH operands) between NUM_REQ requesters, e.g. the integer pipe and the address-gen/CSR unit.
- Per-requester valid/ready request channel; round-robin grant; single result register with a per-requester valid/ready response channel.
- Exactly one operation in flight.
- The ALU is instantiated beside this block, driven from alu_* ports.

Parameters:
- REG_WIDTH, 32, operand/result width
- NUM_REQ, 2, requester count (2..8)
- IDX_W, $clog2(NUM_REQ) (min 1), pointer/owner index width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_rs1  in  NUM_REQ*REG_WIDTH  packed operand 1; requester i at [i*REG_WIDTH +: REG_WIDTH]
- req_rs2  in  NUM_REQ*REG_WIDTH  packed operand 2
- req_cmd  in  NUM_REQ*4  packed ALU command
- resp_valid  out  NUM_REQ  one-hot; owner of held result
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_data  out  REG_WIDTH  held result, shared, qualified by resp_valid
- resp_err  out  1  held command was illegal (1010..1111), qualified by resp_valid
- alu_rs1  out  REG_WIDTH  to ALU rs1
- alu_rs2  out  REG_WIDTH  to ALU rs2
- alu_cmd  out  4  to ALU alu_cmd
- alu_out  in  REG_WIDTH  from ALU out
- busy  out  1  result register occupied

Behaviour:
- Commands:
  - ADD=0000, SUB=0001, SLT=0010, SLTU=0011, AND=0100, OR=0101, XOR=0110, SLL=0111, SRL=1000, SRA=1001.
  - 1010..1111 are illegal. They are still accepted; stored result is 0 and resp_err=1. alu_out is ignored for them.
- States:
  - EMPTY: result register free.
  - FULL: result held for owner.
- Grant (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - can_accept = EMPTY, or FULL && resp_ready[owner] (the response completes this cycle).
  - req_ready[g] = can_accept && req_valid[g]. No grant means all zero.
  - req_ready never depends on another requester's resp_ready except through the owner term above.
- ALU drive:
  - alu_rs1/rs2/cmd = granted requester's fields.
  - When no grant, drive requester rr_ptr's fields; they are don't-care but must not be X-gated.
- Accept (req_valid[g] && req_ready[g] at a rising edge):
  - result ← alu_out, or 0 if illegal.
  - err ← illegal.
  - owner ← g.
  - state ← FULL.
  - rr_ptr ← (g+1) mod NUM_REQ.
- Latency: accept in cycle N → resp_valid[g]=1 with data in cycle N+1. Back-to-back throughput is one op per cycle while owners take responses immediately.
- Response:
  - resp_valid = FULL ? onehot(owner) : 0.
  - Completes on resp_valid[owner] && resp_ready[owner].
  - Completion without a same-cycle accept → EMPTY.
  - Completion with a same-cycle accept → stay FULL with the new result and owner; resp_valid switches owner with no bubble.
- Backpressure: while FULL and the owner's resp_ready=0, all req_ready=0. resp_data, resp_err and resp_valid stay stable, and rr_ptr is unchanged.
- Fairness: with every requester continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 grants.
- busy = FULL.
- Reset (async assert, sync deassert handled externally):
  - state=EMPTY, rr_ptr=0, owner=0, result=0, err=0.
  - Therefore req_ready=0 only if no req_valid; resp_valid=0, resp_data=0, resp_err=0, busy=0.
  - Reset mid-operation discards the held result with no response emitted.
- resp_ready bits of non-owners are ignored.
- req_valid may drop without a handshake; no grant is latched.

Test Plan:
- Reset, then req0 ADD rs1=5, rs2=7; resp_ready0=1 → req_ready0=1 in cycle 0; cycle 1: resp_valid=01, resp_data=12, resp_err=0; cycle 2: busy=0.
- req0 and req1 both valid continuously (req0 SUB 10-3, req1 SRA 0x80000000>>>4), resp_ready=11 → grants alternate 0,1,0,1 starting with 0; results 7 and 0xF8000000; no idle cycle.
- req1 SLTU 1<2, resp_ready1 held 0 for 3 cycles while req0 valid → req_ready=00 for those cycles; resp_data=1 stable; on release, req0 is accepted the same cycle.
- req0 cmd=1011, rs1=rs2=0xFFFFFFFF → resp_valid=01, resp_data=0, resp_err=1.
- Accept req1 XOR, then assert rst_n=0 mid-cycle while FULL → resp_valid=00, busy=0 immediately; after release the first grant is from rr_ptr=0.
- NUM_REQ=3, all valid; requester 2 drops valid before its turn → grant order 0,1,0 with no stall or lockup.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1 for the same requester index. Valid
// may be withdrawn without a transfer; ready never waits on valid being held.
interface alu_share_arbiter_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REQ   = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*REG_WIDTH-1:0] req_rs1;
    logic [NUM_REQ*REG_WIDTH-1:0] req_rs2;
    logic [NUM_REQ*4-1:0]         req_cmd;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [NUM_REQ-1:0]           resp_ready;
    logic [REG_WIDTH-1:0]         resp_data;
    logic                         resp_err;

    modport master (
        output req_valid, req_rs1, req_rs2, req_cmd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_cmd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between
// NUM_REQ requesters. One result register holds the single in-flight result
// until its owner takes it; a new operation may be accepted in the same cycle
// the held result is taken, giving one op per cycle without bubbles.
module alu_share_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REQ   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus,
    output logic [REG_WIDTH-1:0]  alu_rs1,
    output logic [REG_WIDTH-1:0]  alu_rs2,
    output logic [3:0]            alu_cmd,
    input  logic [REG_WIDTH-1:0]  alu_out,
    output logic                  busy,
    output logic                  dbg_state
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr, owner, grant_idx, cand, next_ptr;
    logic                 grant_found, complete, can_accept, accept, illegal;
    logic [REG_WIDTH-1:0] result;
    logic                 err;

    // Index of the requester 'offset' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Round-robin scan from rr_ptr; walking offsets high-to-low lets the nearest valid win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr, k);
            if (bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Accept decision, ALU operand steering and per-requester handshake outputs.
    always_comb begin
        complete   = (state_q == FULL) && bus.resp_ready[owner];
        can_accept = (state_q == EMPTY) || complete;
        accept     = grant_found && can_accept;
        next_ptr   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        // grant_idx falls back to rr_ptr with no grant, so the ALU inputs stay driven.
        alu_rs1    = bus.req_rs1[int'(grant_idx) * REG_WIDTH +: REG_WIDTH];
        alu_rs2    = bus.req_rs2[int'(grant_idx) * REG_WIDTH +: REG_WIDTH];
        alu_cmd    = bus.req_cmd[int'(grant_idx) * 4 +: 4];
        illegal    = (alu_cmd >= 4'd10);
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i]  = accept && (grant_idx == IDX_W'(i));
            bus.resp_valid[i] = (state_q == FULL) && (owner == IDX_W'(i));
        end
    end

    // Next state: an accept always leaves us FULL, even when it overlaps a completion.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if (complete) begin
            state_d = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register, owner and round-robin pointer, all updated only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            err    <= 1'b0;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            result <= illegal ? '0 : alu_out;
            err    <= illegal;
            owner  <= grant_idx;
            rr_ptr <= next_ptr;
        end
    end

    assign bus.resp_data = result;
    assign bus.resp_err  = err;
    assign busy          = (state_q == FULL);
    assign dbg_state     = state_q;
endmodule
